bin_bcd_seq: RTL

//   Multi-cycle binary-to-BCD converter using iterative shift-add-3 (double dabble).

---
 rtl/bin_bcd_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bin_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// A conversion runs IDLE -> SHIFT (BIN_W cycles) -> DONE (one cycle) -> IDLE.
// Results wider than DIGITS decimal digits saturate to all nines and raise ovf.
module bin_bcd_seq #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flag_q, flag_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;

    logic [BCD_W+BIN_W:0] cat_sh;
    logic [BCD_W-1:0]     work_sh;
    logic [BIN_W-1:0]     shift_sh;
    logic                 flag_sh;

    // Add 3 to every digit that is 5 or more; digits are independent, no carry.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = v[4*d +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // One double-dabble step: adjust digits, then shift {work, shift} left by one.
    always_comb begin
        cat_sh   = {1'b0, add3(work_q), shift_q} << 1;
        work_sh  = cat_sh[BCD_W+BIN_W-1 -: BCD_W];
        shift_sh = cat_sh[BIN_W-1:0];
        // A bit leaving the top digit means the value needs more than DIGITS digits.
        flag_sh  = flag_q | cat_sh[BCD_W+BIN_W];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: ready only in IDLE, done only in DONE.
    always_comb begin
        ready = (state_q == S_IDLE);
        done  = (state_q == S_DONE);
    end

    // Datapath next-state: load on accept, shift in SHIFT, publish result on leaving SHIFT.
    always_comb begin
        shift_d = shift_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d = bin_in;
                    work_d  = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    flag_d  = 1'b0;
                end
            end
            S_SHIFT: begin
                shift_d = shift_sh;
                work_d  = work_sh;
                cnt_d   = cnt_q - CNT_W'(1);
                flag_d  = flag_sh;
                // Result registers update here so they are already valid while done is high.
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d = flag_sh ? ALL_NINES : work_sh;
                    ovf_d = flag_sh;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset clears everything so an aborted conversion leaves no trace.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;

endmodule
